alu_dec_issue: RTL and testbench

- Decode/issue stage in front of the single-cycle ALU.
- Accepts raw MIPS32 instruction words plus register-file read data over a valid/ready handshake.
- Decodes opcode/funct into the team's 4-bit ALU opcode and selects the operands it presents on rega/regb.
- Issues through a registered output stage backed by a one-entry skid buffer, so full throughput is kept under backpressure.

---
 rtl/alu_dec_issue_if.sv | 26 ++
 rtl/alu_dec_issue.sv | 171 +++++++++++++++++
 tb/tb_alu_dec_issue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_dec_issue_if.sv
// Instruction-in / issue-out stream bundle for the ALU decode/issue stage.
// master = upstream fetch plus downstream ALU side; slave = the decode/issue block.
interface alu_dec_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs_data;
   logic [31:0] in_rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_aluop;
   logic [31:0] out_rega;
   logic [31:0] out_regb;
   logic [4:0]  out_dest;
   logic        out_wb_en;

   modport master (
      output in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
      input  in_ready, out_valid, out_aluop, out_rega, out_regb, out_dest, out_wb_en
   );

   modport slave (
      input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
      output in_ready, out_valid, out_aluop, out_rega, out_regb, out_dest, out_wb_en
   );
endinterface

// File: rtl/alu_dec_issue.sv
// MIPS32 decode/issue stage: decodes into the 4-bit ALU opcode and issues through a
// registered output slot plus one-entry skid buffer. Define ALU_DEC_MUL_EN to decode SPECIAL2 mul.
module alu_dec_issue #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_dec_issue_if.slave   bus,
   output logic             illegal,
   output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef struct packed {
      logic [3:0]  aluop;
      logic [31:0] rega;
      logic [31:0] regb;
      logic [4:0]  dest;
      logic        wb_en;
   } issue_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        unused_rs_idx;

   assign opcode   = bus.in_instr[31:26];
   assign rt_idx   = bus.in_instr[20:16];
   assign rd_idx   = bus.in_instr[15:11];
   assign shamt    = bus.in_instr[10:6];
   assign funct    = bus.in_instr[5:0];
   assign imm      = bus.in_instr[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};
   // Register indices arrive already resolved as rs/rt data; the rs index itself is not needed.
   assign unused_rs_idx = ^bus.in_instr[25:21];

   issue_t dec;
   logic   dec_legal;

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves a latch behind.
      dec.aluop = 4'b0000;
      dec.rega  = bus.in_rs_data;
      dec.regb  = bus.in_rt_data;
      dec.dest  = (opcode == 6'b000000) ? rd_idx : rt_idx;
      dec.wb_en = 1'b1;
      dec_legal = 1'b1;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b100000: dec.aluop = 4'b0000;
               6'b100001: dec.aluop = 4'b1100;
               6'b100010: dec.aluop = 4'b0001;
               6'b100011: dec.aluop = 4'b1011;
               6'b100100: dec.aluop = 4'b0010;
               6'b100101: dec.aluop = 4'b0011;
               6'b100110: dec.aluop = 4'b0111;
               6'b100111: dec.aluop = 4'b1001;
               6'b101010: dec.aluop = 4'b0110;
               6'b101011: dec.aluop = 4'b0101;
               6'b000100: dec.aluop = 4'b0100;
               6'b000000: begin
                  dec.aluop = 4'b0100;
                  dec.rega  = {27'h0, shamt};
               end
               default:   dec_legal = 1'b0;
            endcase
         end
         6'b001000: begin dec.aluop = 4'b0000; dec.regb = imm_sext; end
         6'b001001: begin dec.aluop = 4'b1100; dec.regb = imm_sext; end
         6'b001010: begin dec.aluop = 4'b0110; dec.regb = imm_sext; end
         6'b001011: begin dec.aluop = 4'b0101; dec.regb = imm_sext; end
         6'b100011: begin dec.aluop = 4'b0000; dec.regb = imm_sext; end
         6'b101011: begin dec.aluop = 4'b0000; dec.regb = imm_sext; dec.wb_en = 1'b0; end
         6'b001100: begin dec.aluop = 4'b0010; dec.regb = imm_zext; end
         6'b001101: begin dec.aluop = 4'b0011; dec.regb = imm_zext; end
         6'b001110: begin dec.aluop = 4'b0111; dec.regb = imm_zext; end
         6'b001111: begin dec.aluop = 4'b1000; dec.regb = imm_zext; end
         6'b000100, 6'b000101: begin
            dec.aluop = 4'b0001;
            dec.dest  = 5'd0;
            dec.wb_en = 1'b0;
         end
         6'b000110: begin
            dec.aluop = 4'b1010;
            dec.rega  = 32'h0;
            dec.regb  = bus.in_rs_data;
            dec.dest  = 5'd0;
            dec.wb_en = 1'b0;
         end
`ifdef ALU_DEC_MUL_EN
         6'b011100: begin
            if (funct == 6'b000010) begin
               dec.aluop = 4'b1101;
               dec.dest  = rd_idx;
            end else begin
               dec_legal = 1'b0;
            end
         end
`else
         6'b011100: dec_legal = 1'b0;
`endif
         default: dec_legal = 1'b0;
      endcase
   end

   issue_t out_q;
   issue_t skid_q;
   logic   out_valid_q;
   logic   skid_full;
   logic   accept;
   logic   push;
   logic   drain;

   // Ready depends only on skid occupancy, so it never combinationally follows out_ready.
   assign bus.in_ready = ~skid_full;
   assign accept       = bus.in_valid & ~skid_full;
   assign push         = accept & dec_legal;
   assign drain        = out_valid_q & bus.out_ready;

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         skid_full   <= 1'b0;
         illegal     <= 1'b0;
         issue_cnt   <= '0;
         illegal_cnt <= '0;
      end else begin
         illegal <= accept & ~dec_legal;
         if (accept && !dec_legal) illegal_cnt <= illegal_cnt + CNT_ONE;
         if (drain) issue_cnt <= issue_cnt + CNT_ONE;

         // A full skid implies a held output; nothing new can be accepted in that state.
         if (skid_full) begin
            if (drain) begin
               out_q     <= skid_q;
               skid_full <= 1'b0;
            end
         end else if (push) begin
            if (!out_valid_q || drain) begin
               out_q       <= dec;
               out_valid_q <= 1'b1;
            end else begin
               skid_q    <= dec;
               skid_full <= 1'b1;
            end
         end else if (drain) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_aluop = out_q.aluop;
   assign bus.out_rega  = out_q.rega;
   assign bus.out_regb  = out_q.regb;
   assign bus.out_dest  = out_q.dest;
   assign bus.out_wb_en = out_q.wb_en;

endmodule

// File: tb/tb_alu_dec_issue.sv
// Bench for alu_dec_issue: decode vector table, backpressure/skid sequences, async reset.
// Expected issue records are queued at acceptance and compared when the output handshakes.
module tb_alu_dec_issue;
   localparam int CNT_W   = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             illegal;
   logic [CNT_W-1:0] issue_cnt;
   logic [CNT_W-1:0] illegal_cnt;

   alu_dec_issue_if bus ();

   alu_dec_issue #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .illegal     (illegal),
      .issue_cnt   (issue_cnt),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] rt;
      bit          legal;
      logic [3:0]  aluop;
      logic [31:0] rega;
      logic [31:0] regb;
      logic [4:0]  dest;
      logic        wb;
   } vec_t;

   typedef struct packed {
      logic [3:0]  aluop;
      logic [31:0] rega;
      logic [31:0] regb;
      logic [4:0]  dest;
      logic        wb;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   int   n_legal = 0;
   int   stalls = 0;
   exp_t sb[$];
   vec_t vecs[$];
   exp_t mon_got;
   exp_t mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                               input bit legal, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] d, input logic wb);
      vec_t v;
      v.instr = instr; v.rs = rs; v.rt = rt; v.legal = legal;
      v.aluop = op; v.rega = a; v.regb = b; v.dest = d; v.wb = wb;
      return v;
   endfunction

   function automatic logic [31:0] r_w(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_w(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Scoreboard side: every completed output handshake must match the oldest queued record.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         mon_got = {bus.out_aluop, bus.out_rega, bus.out_regb, bus.out_dest, bus.out_wb_en};
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_issue: got %0h expected nothing", mon_got);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               bad++;
               $display("FAIL issue: got %0h expected %0h", mon_got, mon_exp);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the edge that accepted the word.
   task automatic send(input vec_t v);
      int  waited = 0;
      bit  done = 0;
      bus.in_valid   = 1'b1;
      bus.in_instr   = v.instr;
      bus.in_rs_data = v.rs;
      bus.in_rt_data = v.rt;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1;
            if (v.legal) begin
               sb.push_back({v.aluop, v.rega, v.regb, v.dest, v.wb});
               n_legal++;
            end
         end else begin
            waited++;
            stalls++;
            if (waited > 200) begin
               total++;
               bad++;
               $display("FAIL accept_timeout: got no in_ready after %0d cycles", waited);
               done = 1;
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain_sb();
      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [31:0] S = 32'h1357_9BDF;
   localparam logic [31:0] T = 32'h2468_ACE0;

   bit   stop;
   vec_t va;
   vec_t vb;
   vec_t vc;

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_instr   = '0;
      bus.in_rs_data = '0;
      bus.in_rt_data = '0;
      bus.out_ready  = 1'b1;

      vecs.push_back(mk(32'h0022_1821, 32'd5, 32'd7, 1, 4'b1100, 32'd5, 32'd7, 5'd3, 1'b1));
      vecs.push_back(mk(32'h2004_FFFF, 32'd0, 32'd9, 1, 4'b0000, 32'd0, 32'hFFFF_FFFF, 5'd4, 1'b1));
      vecs.push_back(mk(32'h3404_FFFF, 32'd0, 32'd9, 1, 4'b0011, 32'd0, 32'h0000_FFFF, 5'd4, 1'b1));
      vecs.push_back(mk(32'h0001_1100, 32'hAA, 32'd1, 1, 4'b0100, 32'd4, 32'd1, 5'd2, 1'b1));
      vecs.push_back(mk(32'h1022_0003, 32'd10, 32'd10, 1, 4'b0001, 32'd10, 32'd10, 5'd0, 1'b0));
      vecs.push_back(mk(r_w(1, 2, 5, 0, 6'b100000), S, T, 1, 4'b0000, S, T, 5'd5, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 6, 0, 6'b100010), S, T, 1, 4'b0001, S, T, 5'd6, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 7, 0, 6'b100011), S, T, 1, 4'b1011, S, T, 5'd7, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 8, 0, 6'b100100), S, T, 1, 4'b0010, S, T, 5'd8, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 9, 0, 6'b100101), S, T, 1, 4'b0011, S, T, 5'd9, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 10, 0, 6'b100110), S, T, 1, 4'b0111, S, T, 5'd10, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 11, 0, 6'b100111), S, T, 1, 4'b1001, S, T, 5'd11, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 12, 0, 6'b101010), S, T, 1, 4'b0110, S, T, 5'd12, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 13, 0, 6'b101011), S, T, 1, 4'b0101, S, T, 5'd13, 1'b1));
      vecs.push_back(mk(r_w(1, 2, 14, 0, 6'b000100), S, T, 1, 4'b0100, S, T, 5'd14, 1'b1));
      vecs.push_back(mk(i_w(6'b001001, 3, 6, 16'h8000), S, T, 1, 4'b1100, S, 32'hFFFF_8000, 5'd6, 1'b1));
      vecs.push_back(mk(i_w(6'b001010, 3, 7, 16'h7FFF), S, T, 1, 4'b0110, S, 32'h0000_7FFF, 5'd7, 1'b1));
      vecs.push_back(mk(i_w(6'b001011, 3, 8, 16'h8001), S, T, 1, 4'b0101, S, 32'hFFFF_8001, 5'd8, 1'b1));
      vecs.push_back(mk(i_w(6'b100011, 3, 9, 16'hFFFC), S, T, 1, 4'b0000, S, 32'hFFFF_FFFC, 5'd9, 1'b1));
      vecs.push_back(mk(i_w(6'b101011, 3, 10, 16'h0010), S, T, 1, 4'b0000, S, 32'h0000_0010, 5'd10, 1'b0));
      vecs.push_back(mk(i_w(6'b001100, 3, 11, 16'h8000), S, T, 1, 4'b0010, S, 32'h0000_8000, 5'd11, 1'b1));
      vecs.push_back(mk(i_w(6'b001110, 3, 12, 16'hABCD), S, T, 1, 4'b0111, S, 32'h0000_ABCD, 5'd12, 1'b1));
      vecs.push_back(mk(i_w(6'b001111, 0, 13, 16'h1234), S, T, 1, 4'b1000, S, 32'h0000_1234, 5'd13, 1'b1));
      vecs.push_back(mk(i_w(6'b000101, 1, 2, 16'hFFFE), S, T, 1, 4'b0001, S, T, 5'd0, 1'b0));
      vecs.push_back(mk(i_w(6'b000110, 1, 0, 16'h0004), 32'h8000_0000, T, 1, 4'b1010, 32'd0,
                        32'h8000_0000, 5'd0, 1'b0));
      vecs.push_back(mk(32'hFC00_0000, S, T, 0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0));
      vecs.push_back(mk(r_w(1, 2, 3, 0, 6'b111111), S, T, 0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0));
      vecs.push_back(mk(i_w(6'b000010, 0, 0, 16'h0040), S, T, 0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0));
`ifdef ALU_DEC_MUL_EN
      vecs.push_back(mk(32'h7022_1002, S, T, 1, 4'b1101, S, T, 5'd2, 1'b1));
`else
      vecs.push_back(mk(32'h7022_1002, S, T, 0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0));
`endif
      vecs.push_back(mk(r_w(4, 5, 17, 0, 6'b100001), 32'd100, 32'd200, 1, 4'b1100, 32'd100, 32'd200,
                        5'd17, 1'b1));

      // Reset state, asserted mid-cycle.
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_payload", {bus.out_aluop, bus.out_dest, bus.out_wb_en, 22'd0}, 32'd0);
      check("rst_rega", bus.out_rega, 32'd0);
      check("rst_regb", bus.out_regb, 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_cnts", {24'd0, issue_cnt, illegal_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First transaction: one-cycle latency then one completed handshake.
      send(vecs[0]);
      idle();
      check("first_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
      check("first_issue_cnt", 32'(issue_cnt), 32'd1);

      // Decode table streamed back to back with the sink always ready.
      stalls = 0;
      foreach (vecs[i]) begin
         send(vecs[i]);
         check($sformatf("illegal_pulse[%0d]", i), 32'(illegal), vecs[i].legal ? 32'd0 : 32'd1);
      end
      idle();
      check("full_rate_stalls", 32'(stalls), 32'd0);
      drain_sb();
      check("illegal_clear", 32'(illegal), 32'd0);
      check("illegal_cnt", 32'(illegal_cnt), 32'((vecs.size() + 1 - n_legal) % CNT_MOD));
      check("issue_cnt_wrap", 32'(issue_cnt), 32'(n_legal % CNT_MOD));

      // Backpressure: A held on output, B in skid, C must wait until the sink drains.
      va = mk(r_w(1, 2, 20, 0, 6'b100001), 32'hA0, 32'h1, 1, 4'b1100, 32'hA0, 32'h1, 5'd20, 1'b1);
      vb = mk(r_w(1, 2, 21, 0, 6'b100001), 32'hB0, 32'h2, 1, 4'b1100, 32'hB0, 32'h2, 5'd21, 1'b1);
      vc = mk(r_w(1, 2, 22, 0, 6'b100001), 32'hC0, 32'h3, 1, 4'b1100, 32'hC0, 32'h3, 5'd22, 1'b1);
      bus.out_ready = 1'b0;
      send(va);
      send(vb);
      check("skid_full_ready", 32'(bus.in_ready), 32'd0);
      fork
         send(vc);
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check("hold_valid", 32'(bus.out_valid), 32'd1);
               check("hold_rega", bus.out_rega, 32'hA0);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      idle();
      drain_sb();
      check("ready_restored", 32'(bus.in_ready), 32'd1);

      // Random sink stalls with a continuous source; order and count must hold.
      stop = 0;
      fork
         begin
            for (int k = 0; k < 24; k++) begin
               vc = mk(r_w(1, 2, 5'(k), 0, 6'b100000), 32'(k * 3), 32'(k), 1, 4'b0000,
                       32'(k * 3), 32'(k), 5'(k), 1'b1);
               send(vc);
            end
            idle();
            stop = 1;
         end
         begin
            while (!stop) begin
               @(posedge clk);
               #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      drain_sb();
      check("stress_issue_cnt", 32'(issue_cnt), 32'(n_legal % CNT_MOD));

      // Asynchronous reset with both entries occupied.
      bus.out_ready = 1'b0;
      send(va);
      send(vb);
      idle();
      check("pre_rst_full", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
      #2 rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_in_ready", 32'(bus.in_ready), 32'd1);
      check("async_cnts", {24'd0, issue_cnt, illegal_cnt}, 32'd0);
      sb.delete();
      n_legal = 0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("no_ghost_issue", 32'(bus.out_valid), 32'd0);
      send(vecs[0]);
      idle();
      drain_sb();
      check("post_rst_issue_cnt", 32'(issue_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
